// File: rtl/wb_irq_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller: register word indexes,
// ID layout and small helpers used by the top level.
package wb_irq_ctrl_pkg;

    localparam int unsigned REG_W        = 32;
    localparam int unsigned ID_VALID_BIT = 31;

    // Word indexes taken from wb_adr_i[4:2]
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_PENDING  = 3'd2;
    localparam logic [2:0] REG_MODE     = 3'd3;
    localparam logic [2:0] REG_POLARITY = 3'd4;
    localparam logic [2:0] REG_ID       = 3'd5;

    function automatic logic [REG_W-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [4:0] lowest_set(input logic [REG_W-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = int'(REG_W) - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_irq_ctrl_irq_sync.sv
// One interrupt source: 2-flop synchroniser, polarity correction and rising-edge
// detect on the corrected (active) signal.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic pol,
    output logic act,
    output logic rise
);

    logic [1:0] sync_q;
    logic       act_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            act_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], irq};
            act_q  <= act;
        end
    end

    // A polarity flip that makes act rise is reported as an edge too.
    assign act  = sync_q[1] ^ pol;
    assign rise = act & ~act_q;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone classic interrupt controller: per-source level/edge capture, enable
// masking, lowest-index ID and a registered combined interrupt.
module wb_irq_ctrl
    import wb_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 32,
    parameter logic [31:0] RESET_MODE = 32'h0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [4:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               irq_o
);

    localparam logic [REG_W-1:0] IRQ_MASK =
        (NUM_IRQ >= REG_W) ? {REG_W{1'b1}} : ((32'(1) << NUM_IRQ) - 32'(1));

    logic [REG_W-1:0] en_q, en_d;
    logic [REG_W-1:0] pend_q, pend_d;
    logic [REG_W-1:0] mode_q, mode_d;
    logic [REG_W-1:0] pol_q, pol_d;
    logic [REG_W-1:0] act, rise, w1c, active, wmask, wdata, rdata, id_val;
    logic [31:0]      dat_q;
    logic             ack_q, err_q, irq_q;
    logic             req, adr_ok, wr;
    logic [2:0]       reg_sel;
    logic             unused_ok;

    for (genvar gi = 0; gi < int'(REG_W); gi++) begin : g_src
        if (gi < int'(NUM_IRQ)) begin : g_on
            irq_sync_edge u_sync (
                .clk  (wb_clk_i),
                .rst  (wb_rst_i),
                .irq  (irq_i[gi]),
                .pol  (pol_q[gi]),
                .act  (act[gi]),
                .rise (rise[gi])
            );
        end else begin : g_off
            assign act[gi]  = 1'b0;
            assign rise[gi] = 1'b0;
        end
    end

    // A new request is only accepted once the previous termination has dropped.
    assign req     = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
    assign reg_sel = wb_adr_i[4:2];
    assign adr_ok  = (reg_sel <= REG_ID);
    assign wr      = req & wb_we_i & adr_ok;
    assign wmask   = byte_mask(wb_sel_i) & IRQ_MASK;
    assign wdata   = wb_dat_i & wmask;
    assign active  = pend_q & en_q;
    assign id_val  = {(active != '0), 26'd0, lowest_set(active)};

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS:   rdata = active;
            REG_ENABLE:   rdata = en_q;
            REG_PENDING:  rdata = pend_q;
            REG_MODE:     rdata = mode_q;
            REG_POLARITY: rdata = pol_q;
            REG_ID:       rdata = id_val;
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        w1c    = '0;
        if (wr) begin
            case (reg_sel)
                REG_ENABLE:   en_d   = (en_q & ~wmask) | wdata;
                REG_PENDING:  w1c    = wdata;
                REG_MODE:     mode_d = (mode_q & ~wmask) | wdata;
                REG_POLARITY: pol_d  = (pol_q & ~wmask) | wdata;
                default:      ;
            endcase
        end
        // Edge bits: a fresh edge beats a simultaneous clear. Level bits follow act.
        pend_d = ((mode_q & ((pend_q & ~w1c) | rise)) | (~mode_q & act)) & IRQ_MASK;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q   <= '0;
            pend_q <= '0;
            mode_q <= RESET_MODE & IRQ_MASK;
            pol_q  <= '0;
            irq_q  <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            en_q   <= en_d;
            pend_q <= pend_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            irq_q  <= |active;
            ack_q  <= req & adr_ok;
            err_q  <= req & ~adr_ok;
            dat_q  <= (req & adr_ok) ? rdata : '0;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_rty_o  = 1'b0;
    assign irq_o     = irq_q;
    assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Self-checking bench for wb_irq_ctrl: directed scenarios plus a randomized run
// against a register-level behavioural model; a second 8-source instance covers width.
module tb_wb_irq_ctrl;

    localparam logic [31:0] RM0 = 32'h0000_0100;
    localparam logic [31:0] RM8 = 32'h0000_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        dsel = 1'b0;
    logic [31:0] irq0 = '0;
    logic [7:0]  irq8 = '0;

    logic [31:0] dout0, dout8;
    logic        ack0, err0, rty0, irq_o0;
    logic        ack8, err8, rty8, irq_o8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_irq_ctrl #(.NUM_IRQ(32), .RESET_MODE(RM0)) dut0 (
        .wb_clk_i (clk), .wb_rst_i (rst), .wb_adr_i (adr), .wb_dat_i (dat_i),
        .wb_sel_i (sel), .wb_we_i (we), .wb_cyc_i (cyc & ~dsel), .wb_stb_i (stb & ~dsel),
        .wb_cti_i (cti), .wb_bte_i (bte), .wb_dat_o (dout0), .wb_ack_o (ack0),
        .wb_err_o (err0), .wb_rty_o (rty0), .irq_i (irq0), .irq_o (irq_o0)
    );

    wb_irq_ctrl #(.NUM_IRQ(8), .RESET_MODE(RM8)) dut8 (
        .wb_clk_i (clk), .wb_rst_i (rst), .wb_adr_i (adr), .wb_dat_i (dat_i),
        .wb_sel_i (sel), .wb_we_i (we), .wb_cyc_i (cyc & dsel), .wb_stb_i (stb & dsel),
        .wb_cti_i (cti), .wb_bte_i (bte), .wb_dat_o (dout8), .wb_ack_o (ack8),
        .wb_err_o (err8), .wb_rty_o (rty8), .irq_i (irq8), .irq_o (irq_o8)
    );

    task automatic bus(input logic d, input logic w, input logic [4:0] a,
                       input logic [31:0] wd, input logic [3:0] s,
                       output logic [31:0] rd, output logic got_ack, output logic got_err);
        int n;
        @(negedge clk);
        dsel = d; adr = a; dat_i = wd; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        cti = 3'($urandom); bte = 2'($urandom);
        n = 0; got_ack = 1'b0; got_err = 1'b0;
        while (n < 16 && !got_ack && !got_err) begin
            @(posedge clk); #1;
            n++;
            got_ack = d ? ack8 : ack0;
            got_err = d ? err8 : err0;
        end
        rd = d ? dout8 : dout0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got_ack && !got_err) begin
            checks++; errors++;
            $display("FAIL bus_timeout adr=%h got no termination within 16 cycles", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic d, input logic [4:0] a, input logic [31:0] v,
                      input logic [3:0] s);
        logic [31:0] rd; logic ka, ke;
        bus(d, 1'b1, a, v, s, rd, ka, ke);
    endtask

    task automatic rdreg(input logic d, input logic [4:0] a, output logic [31:0] v);
        logic ka, ke;
        bus(d, 1'b0, a, 32'h0, 4'hF, v, ka, ke);
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [6];
        logic [31:0] v;
        exp_v = '{32'h0, 32'h0, 32'h0, RM0, 32'h0, 32'h0};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({irq_o0, ack0, err0, rty0, irq_o8, ack8, err8, rty8} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000",
                     {irq_o0, ack0, err0, rty0, irq_o8, ack8, err8, rty8});
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rdreg(1'b0, 5'(i * 4), v);
            checks++;
            if (v !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_reg%0d got %h want %h", i, v, exp_v[i]);
            end
        end
        rdreg(1'b1, 5'h0C, v);
        checks++;
        if (v !== 32'h0000_000F) begin
            errors++;
            $display("FAIL reset_mode8 got %h want 0000000f", v);
        end
    endtask

    task automatic test_edge_latency();
        logic [31:0] v;
        wr(1'b0, 5'h04, 32'h4, 4'hF);
        wr(1'b0, 5'h0C, 32'h4, 4'hF);
        @(negedge clk) irq0 = 32'h4;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e == 3) begin
                checks++;
                if (irq_o0 !== 1'b0) begin
                    errors++;
                    $display("FAIL edge_irq_edge3 got %b want 0", irq_o0);
                end
            end
            if (e == 4) begin
                checks++;
                if (irq_o0 !== 1'b1) begin
                    errors++;
                    $display("FAIL edge_irq_edge4 got %b want 1", irq_o0);
                end
            end
            if (e == 1) begin
                @(negedge clk) irq0 = 32'h0;
            end
        end
        rdreg(1'b0, 5'h14, v);
        checks++;
        if (v !== 32'h8000_0002) begin
            errors++;
            $display("FAIL edge_id got %h want 80000002", v);
        end
        wr(1'b0, 5'h08, 32'h4, 4'hF);
        checks++;
        if (irq_o0 !== 1'b0) begin
            errors++;
            $display("FAIL edge_w1c_irq got %b want 0", irq_o0);
        end
        rdreg(1'b0, 5'h08, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL edge_w1c_pending got %h want 0", v);
        end
    endtask

    task automatic test_level();
        logic [31:0] v;
        wr(1'b0, 5'h0C, 32'h0, 4'hF);
        wr(1'b0, 5'h04, 32'h3, 4'hF);
        irq0 = 32'h3;
        settle();
        rdreg(1'b0, 5'h14, v);
        checks++;
        if (v !== 32'h8000_0000) begin
            errors++;
            $display("FAIL level_id0 got %h want 80000000", v);
        end
        wr(1'b0, 5'h08, 32'h1, 4'hF);
        rdreg(1'b0, 5'h08, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL level_w1c_ignored got %h want 00000003", v);
        end
        irq0 = 32'h2;
        settle();
        rdreg(1'b0, 5'h14, v);
        checks++;
        if (v !== 32'h8000_0001) begin
            errors++;
            $display("FAIL level_id1 got %h want 80000001", v);
        end
        checks++;
        if (irq_o0 !== 1'b1) begin
            errors++;
            $display("FAIL level_irq got %b want 1", irq_o0);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        irq0 = 32'h0;
        settle();
        wr(1'b0, 5'h0C, 32'h20, 4'hF);
        wr(1'b0, 5'h08, 32'hFFFF_FFFF, 4'hF);
        rdreg(1'b0, 5'h08, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL setwins_clear got %h want 0", v);
        end
        // Edge reaches PENDING on the 3rd edge; the W1C ack lands on that same edge.
        @(negedge clk) irq0 = 32'h20;
        @(posedge clk);
        @(posedge clk);
        wr(1'b0, 5'h08, 32'h20, 4'hF);
        rdreg(1'b0, 5'h08, v);
        checks++;
        if (v !== 32'h20) begin
            errors++;
            $display("FAIL setwins_pending got %h want 00000020", v);
        end
        wr(1'b0, 5'h08, 32'h20, 4'hF);
        rdreg(1'b0, 5'h08, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL setwins_later_w1c got %h want 0", v);
        end
    endtask

    task automatic test_err();
        logic [31:0] v;
        logic ka, ke;
        wr(1'b0, 5'h04, 32'h1234_5678, 4'hF);
        bus(1'b0, 1'b0, 5'h18, 32'h0, 4'hF, v, ka, ke);
        checks++;
        if ({ke, ka, v} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL err_read18 got err=%b ack=%b dat=%h want err=1 ack=0 dat=0", ke, ka, v);
        end
        bus(1'b0, 1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, v, ka, ke);
        checks++;
        if ({ke, ka} !== 2'b10) begin
            errors++;
            $display("FAIL err_write1c got err=%b ack=%b want err=1 ack=0", ke, ka);
        end
        rdreg(1'b0, 5'h04, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL err_no_side_effect got %h want 12345678", v);
        end
        wr(1'b0, 5'h04, 32'h0, 4'hF);
        wr(1'b0, 5'h04, 32'hFFFF_FFFF, 4'b0001);
        wr(1'b0, 5'h00, 32'hFFFF_FFFF, 4'hF);
        wr(1'b0, 5'h14, 32'hFFFF_FFFF, 4'hF);
        rdreg(1'b0, 5'h04, v);
        checks++;
        if (v !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL err_bytesel got %h want 000000ff", v);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        logic prev, a, dbl;
        @(negedge clk);
        dsel = 1'b0; adr = 5'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acks = 0; prev = 1'b0; dbl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a = ack0;
            if (a) acks++;
            if (a && prev) dbl = 1'b1;
            prev = a;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (acks != 4 || dbl) begin
            errors++;
            $display("FAIL b2b_acks got %0d acks (consecutive=%b) want 4 (consecutive=0)",
                     acks, dbl);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_en, m_pend, m_mode, m_pol, m_act, act_new, r, bm, v, exp_id, act_v;
        logic [3:0] s;
        int op;
        irq0 = 32'h0;
        wr(1'b0, 5'h10, 32'h0, 4'hF);
        wr(1'b0, 5'h0C, 32'h0, 4'hF);
        wr(1'b0, 5'h04, 32'h0, 4'hF);
        settle();
        m_en = '0; m_pend = '0; m_mode = '0; m_pol = '0; m_act = '0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            r = $urandom;
            s = 4'($urandom_range(0, 15));
            bm = '0;
            for (int b = 0; b < 4; b++) if (s[b]) bm[b*8 +: 8] = 8'hFF;
            act_new = m_act;
            case (op)
                0: begin irq0 = r; act_new = r ^ m_pol; end
                1: begin wr(1'b0, 5'h10, r, 4'hF); m_pol = r; act_new = irq0 ^ m_pol; end
                2: begin
                    wr(1'b0, 5'h0C, r, 4'hF);
                    m_mode = r;
                    m_pend = (m_pend & m_mode) | (m_act & ~m_mode);
                end
                3: begin wr(1'b0, 5'h04, r, s); m_en = (m_en & ~bm) | (r & bm); end
                default: begin wr(1'b0, 5'h08, r, s); m_pend = m_pend & ~(r & bm & m_mode); end
            endcase
            for (int n = 0; n < 32; n++) begin
                if (m_mode[n]) m_pend[n] = m_pend[n] | (act_new[n] & ~m_act[n]);
                else           m_pend[n] = act_new[n];
            end
            m_act = act_new;
            settle();
            act_v = m_pend & m_en;
            exp_id = '0;
            for (int n = 31; n >= 0; n--) if (act_v[n]) exp_id = 32'h8000_0000 + n;
            rdreg(1'b0, 5'h00, v);
            checks++;
            if (v !== act_v) begin
                errors++;
                $display("FAIL rnd_status it=%0d got %h want %h", it, v, act_v);
            end
            rdreg(1'b0, 5'h08, v);
            checks++;
            if (v !== m_pend) begin
                errors++;
                $display("FAIL rnd_pending it=%0d got %h want %h", it, v, m_pend);
            end
            rdreg(1'b0, 5'h14, v);
            checks++;
            if (v !== exp_id) begin
                errors++;
                $display("FAIL rnd_id it=%0d got %h want %h", it, v, exp_id);
            end
            checks++;
            if (irq_o0 !== (act_v != 0)) begin
                errors++;
                $display("FAIL rnd_irq it=%0d got %b want %b", it, irq_o0, act_v != 0);
            end
            rdreg(1'b0, 5'h04, v);
            checks++;
            if (v !== m_en) begin
                errors++;
                $display("FAIL rnd_enable it=%0d got %h want %h", it, v, m_en);
            end
        end
    endtask

    task automatic test_narrow();
        logic [31:0] v;
        wr(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF);
        rdreg(1'b1, 5'h04, v);
        checks++;
        if (v !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL n8_enable got %h want 000000ff", v);
        end
        // Inverting polarity with inputs low makes every act rise, edge bits included.
        wr(1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF);
        settle();
        rdreg(1'b1, 5'h08, v);
        checks++;
        if (v !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL n8_pending got %h want 000000ff", v);
        end
        rdreg(1'b1, 5'h14, v);
        checks++;
        if (v !== 32'h8000_0000) begin
            errors++;
            $display("FAIL n8_id got %h want 80000000", v);
        end
        @(negedge clk);
        dsel = 1'b1; adr = 5'h04; dat_i = 32'h5A; sel = 4'hF; we = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack8 !== 1'b0) begin
            errors++;
            $display("FAIL n8_rst_ack got %b want 0", ack8);
        end
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ack8, irq_o8, irq_o0} !== 3'b000) begin
            errors++;
            $display("FAIL n8_post_rst got ack/irq8/irq0=%b want 000", {ack8, irq_o8, irq_o0});
        end
        rdreg(1'b1, 5'h04, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL n8_rst_enable got %h want 0", v);
        end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_level();
        test_set_wins();
        test_err();
        test_back_to_back();
        test_random();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/wb_irq_ctrl.md
WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 32, number of interrupt sources (1..32).
REQ-002 Parameter RESET_MODE, default 32'h0, reset value of MODE register (0 = level, 1 = edge per source).
REQ-003 wb_clk_i  in  1  single clock for all logic.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 wb_adr_i  in  5  byte address; [4:2] selects register, [1:0] ignored.
REQ-006 wb_dat_i  in  32  write data.
REQ-007 wb_sel_i  in  4  byte enables for writes.
REQ-008 wb_we_i / wb_cyc_i / wb_stb_i  in  1 each  Wishbone classic controls.
REQ-009 wb_cti_i  in  3, wb_bte_i  in  2  accepted and ignored; every access is treated as a classic single cycle.
REQ-010 wb_dat_o  out  32  read data.
REQ-011 wb_ack_o / wb_err_o / wb_rty_o  out  1 each  termination; wb_rty_o is tied 0.
REQ-012 irq_i  in  NUM_IRQ  asynchronous interrupt sources.
REQ-013 irq_o  out  1  registered, combined interrupt to the CPU.

Function
REQ-014 Register map: 0x00 STATUS (RO) = PENDING & ENABLE; 0x04 ENABLE (RW); 0x08 PENDING (RO raw, W1C); 0x0C MODE (RW); 0x10 POLARITY (RW, 1 = active-low/falling); 0x14 ID (RO).
REQ-015 Bits at or above NUM_IRQ in every register read 0, and writes to them are ignored.
REQ-016 Each irq_i bit passes through a 2-flop synchroniser, then XOR with POLARITY, giving the active signal act[n].
REQ-017 Level mode (MODE[n]=0): PENDING[n] <= act[n] every cycle; W1C has no effect.
REQ-018 Edge mode (MODE[n]=1): PENDING[n] sets on a 0->1 transition of act[n] and clears only via a W1C write.
REQ-019 If an edge and a W1C hit the same bit in the same cycle, set wins.
REQ-020 Latency: an irq_i rise is seen in PENDING at the 3rd rising clock edge and in irq_o at the 4th.
REQ-021 irq_o <= |(PENDING & ENABLE), registered.
REQ-022 ID: bit 31 = |(PENDING & ENABLE); bits [4:0] = lowest index n with PENDING[n]&ENABLE[n], else 0; bits [30:5] = 0.
REQ-023 Bus handshake: when wb_cyc_i & wb_stb_i & ~ack_or_err_pending, exactly one of ack/err pulses high for 1 cycle on the next clock edge. ack_or_err_pending is the termination pulse already high.
REQ-024 No termination is issued in the cycle after a termination; back-to-back accesses therefore take 2 cycles each.
REQ-025 Writes take effect on the same edge that raises ack; only bytes with wb_sel_i set are written.
REQ-026 Reads return registered data valid while ack is high.
REQ-027 Address 0x18-0x1C raises wb_err_o instead of ack, with no side effects; wb_dat_o = 0.
REQ-028 Writes to RO registers (STATUS, ID) are acked and ignored.
REQ-029 A MODE or POLARITY change does not by itself set PENDING in edge mode unless act[n] rises as a result. Rising as a result is allowed and documented.
REQ-030 If the master drops stb before termination, the pending termination still pulses once. Masters shall not do this.

Reset
REQ-031 On wb_rst_i asserting: ENABLE=0, PENDING=0, POLARITY=0, MODE=RESET_MODE, synchronisers=0, irq_o=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
REQ-032 Reset mid-transfer aborts the access with no termination; the register write is not performed.

Structure
REQ-033 Shared package wb_irq_ctrl_pkg holds the register offsets, the ID valid-bit position and the register width constant.
REQ-034 One sub-module, irq_sync_edge, per source: synchroniser, polarity XOR and edge detect, instantiated NUM_IRQ times by generate.

Verification
REQ-035 Reset, then read all 6 registers -> 0,0,0,RESET_MODE,0,0; irq_o=0.
REQ-036 ENABLE=0x4, MODE=0x4, pulse irq_i[2] high for 1 cycle -> irq_o high on the 4th edge; ID=0x80000002; W1C PENDING=0x4 -> irq_o low 2 cycles later.
REQ-037 Level mode, ENABLE=0x3, irq_i=0x3 -> ID=0x80000000; W1C 0x1 leaves PENDING=0x3; drop irq_i[0] -> ID=0x80000001.
REQ-038 Edge mode bit 5: an edge coincides with a W1C of bit 5 -> PENDING[5] stays 1.
REQ-039 Read 0x18 -> err pulse, no ack, state unchanged; write ENABLE with sel=4'b0001, data 0xFFFFFFFF -> ENABLE=0x000000FF.
REQ-040 NUM_IRQ=8: write ENABLE=0xFFFFFFFF -> reads 0x000000FF. Assert wb_rst_i during an ack-pending write -> no ack, ENABLE=0.
